// File: rtl/snake_pkg.sv
// Shared link definitions: opcodes, frame encoder, transmit FSM states and the direction type.
package snake_pkg;

  typedef logic [2:0] direction;

  localparam logic [1:0] LINK_OP_DIR   = 2'b00;
  localparam logic [1:0] LINK_OP_SEEDX = 2'b01;
  localparam logic [1:0] LINK_OP_SEEDY = 2'b10;
  localparam logic [1:0] LINK_OP_EVT   = 2'b11;

  localparam logic [4:0] LINK_HB_CODE = 5'h1F;

  typedef enum logic [2:0] {
    LINK_IDLE   = 3'd0,
    LINK_SEED_X = 3'd1,
    LINK_SEED_Y = 3'd2,
    LINK_SINGLE = 3'd3,
    LINK_GAP    = 3'd4
  } link_tx_state;

  function automatic logic [7:0] link_frame(input logic [1:0] op, input logic [4:0] payload);
    return {op, 1'b0, payload};
  endfunction

endpackage

// File: rtl/link_heartbeat_timer.sv
// Idle counter for the link heartbeat; built only when LINK_HEARTBEAT_EN is defined.
module link_heartbeat_timer #(
  parameter int unsigned HB_PERIOD = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic singleplayer,
  input  logic wr_uart,
  input  logic hb_sent,
  output logic hb_pending
);

  localparam int CNT_W = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HB_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  // Any frame on the wire restarts the idle interval; a heartbeat write retires the request.
  always_ff @(posedge clk) begin
    if (rst || singleplayer) begin
      cnt        <= '0;
      hb_pending <= 1'b0;
    end else begin
      if (wr_uart) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt        <= '0;
        hb_pending <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (hb_sent) hb_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/link_tx_arbiter.sv
// Arbitrates seed/event/direction (and optional heartbeat, LINK_HEARTBEAT_EN) frames
// onto the UART TX write port, keeping the seed X/Y pair adjacent on the wire.
module link_tx_arbiter
  import snake_pkg::*;
#(
  parameter int unsigned HB_PERIOD = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       singleplayer,
  input  logic       seed_req,
  input  logic [4:0] seed_x,
  input  logic [4:0] seed_y,
  output logic       seed_ack,
  input  logic       dir_req,
  input  direction   dir,
  output logic       dir_ack,
  input  logic       evt_req,
  input  logic [4:0] evt_code,
  output logic       evt_ack,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy
);

  link_tx_state state, state_nx;
  logic       y_due, y_due_nx;
  logic [4:0] hold_y, hold_y_nx;
  logic       wr_nx, seed_ack_nx, dir_ack_nx, evt_ack_nx;
  logic       hb_wr, hb_wr_nx;
  logic [7:0] data_nx;
  logic       hb_pending;
  logic       seed_rq, dir_rq, evt_rq, seed_inflight;

`ifdef LINK_HEARTBEAT_EN
  link_heartbeat_timer #(
    .HB_PERIOD(HB_PERIOD)
  ) u_hb_timer (
    .clk          (clk),
    .rst          (rst),
    .singleplayer (singleplayer),
    .wr_uart      (wr_uart),
    .hb_sent      (hb_wr),
    .hb_pending   (hb_pending)
  );
`else
  logic hb_unused;
  assign hb_pending = 1'b0;
  assign hb_unused  = hb_wr | (HB_PERIOD == 0);
`endif

  // A request whose ack is currently showing was already served.
  assign seed_rq = seed_req & ~seed_ack;
  assign dir_rq  = dir_req  & ~dir_ack;
  assign evt_rq  = evt_req  & ~evt_ack;

  assign seed_inflight = (state == LINK_SEED_X) | y_due | ((state == LINK_SEED_Y) & ~wr_uart);

  always_comb begin
    state_nx    = state;
    y_due_nx    = y_due;
    hold_y_nx   = hold_y;
    wr_nx       = 1'b0;
    data_nx     = 8'h00;
    seed_ack_nx = 1'b0;
    dir_ack_nx  = 1'b0;
    evt_ack_nx  = 1'b0;
    hb_wr_nx    = 1'b0;

    if (singleplayer) begin
      state_nx    = LINK_IDLE;
      y_due_nx    = 1'b0;
      seed_ack_nx = ~seed_ack & (seed_req | seed_inflight);
      dir_ack_nx  = dir_rq;
      evt_ack_nx  = evt_rq;
    end else begin
      case (state)
        LINK_IDLE: begin
          if (!tx_full && !wr_uart) begin
            if (seed_rq) begin
              state_nx  = LINK_SEED_X;
              wr_nx     = 1'b1;
              data_nx   = link_frame(LINK_OP_SEEDX, seed_x);
              hold_y_nx = seed_y;
            end else if (evt_rq) begin
              state_nx   = LINK_SINGLE;
              wr_nx      = 1'b1;
              data_nx    = link_frame(LINK_OP_EVT, evt_code);
              evt_ack_nx = 1'b1;
            end else if (dir_rq) begin
              state_nx   = LINK_SINGLE;
              wr_nx      = 1'b1;
              data_nx    = link_frame(LINK_OP_DIR, {2'b00, dir});
              dir_ack_nx = 1'b1;
            end else if (hb_pending) begin
              state_nx = LINK_SINGLE;
              wr_nx    = 1'b1;
              data_nx  = link_frame(LINK_OP_EVT, LINK_HB_CODE);
              hb_wr_nx = 1'b1;
            end
          end
        end
        LINK_SEED_X: begin
          state_nx = LINK_GAP;
          y_due_nx = 1'b1;
        end
        // The Y decision is taken here so Y follows X after exactly one gap cycle.
        LINK_GAP: begin
          if (y_due) begin
            state_nx = LINK_SEED_Y;
            y_due_nx = 1'b0;
            if (!tx_full) begin
              wr_nx       = 1'b1;
              data_nx     = link_frame(LINK_OP_SEEDY, hold_y);
              seed_ack_nx = 1'b1;
            end
          end else begin
            state_nx = LINK_IDLE;
          end
        end
        LINK_SEED_Y: begin
          if (wr_uart) begin
            state_nx = LINK_GAP;
          end else if (!tx_full) begin
            wr_nx       = 1'b1;
            data_nx     = link_frame(LINK_OP_SEEDY, hold_y);
            seed_ack_nx = 1'b1;
          end
        end
        LINK_SINGLE: state_nx = LINK_GAP;
        default:     state_nx = LINK_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LINK_IDLE;
      y_due    <= 1'b0;
      hold_y   <= '0;
      wr_uart  <= 1'b0;
      w_data   <= '0;
      seed_ack <= 1'b0;
      dir_ack  <= 1'b0;
      evt_ack  <= 1'b0;
      hb_wr    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      y_due    <= y_due_nx;
      hold_y   <= hold_y_nx;
      wr_uart  <= wr_nx;
      w_data   <= data_nx;
      seed_ack <= seed_ack_nx;
      dir_ack  <= dir_ack_nx;
      evt_ack  <= evt_ack_nx;
      hb_wr    <= hb_wr_nx;
      busy     <= (state_nx != LINK_IDLE);
    end
  end

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Directed bench for link_tx_arbiter; inputs change and outputs are observed on the falling edge.
module tb_link_tx_arbiter;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       rst, singleplayer, seed_req, dir_req, evt_req, tx_full;
  logic [4:0] seed_x, seed_y, evt_code;
  direction   dir;
  logic       seed_ack, dir_ack, evt_ack, wr_uart, busy;
  logic [7:0] w_data;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  link_tx_arbiter #(.HB_PERIOD(16)) dut (
    .clk(clk), .rst(rst), .singleplayer(singleplayer),
    .seed_req(seed_req), .seed_x(seed_x), .seed_y(seed_y), .seed_ack(seed_ack),
    .dir_req(dir_req), .dir(dir), .dir_ack(dir_ack),
    .evt_req(evt_req), .evt_code(evt_code), .evt_ack(evt_ack),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .busy(busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++;
    if ({wr_uart, w_data, busy, seed_ack, dir_ack, evt_ack} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs: wr=%b data=%h busy=%b acks=%b%b%b required all 0",
               wr_uart, w_data, busy, seed_ack, dir_ack, evt_ack);
    end
    rst = 1'b0;
    tick();
    total++;
    if (wr_uart !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: wr=%b busy=%b required 0 0", wr_uart, busy);
    end
  endtask

  task automatic test_dir();
    int writes;
    dir = 3'b010; dir_req = 1'b1;
    tick();
    total++;
    if (wr_uart !== 1'b1 || w_data !== 8'h02 || dir_ack !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL dir_write: wr=%b data=%h ack=%b busy=%b required 1 02 1 1", wr_uart, w_data, dir_ack, busy);
    end
    tick();
    dir_req = 1'b0;
    total++;
    if (wr_uart !== 1'b0 || dir_ack !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL dir_gap: wr=%b ack=%b busy=%b required 0 0 1", wr_uart, dir_ack, busy);
    end
    writes = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wr_uart) writes++;
    end
    total++;
    if (writes != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL dir_no_repeat: writes=%0d busy=%b required 0 0", writes, busy);
    end
  endtask

  task automatic test_seed_dir();
    seed_x = 5'd7; seed_y = 5'd19; seed_req = 1'b1;
    dir = 3'b101; dir_req = 1'b1;
    tick();
    seed_y = 5'd0;
    total++;
    if (wr_uart !== 1'b1 || w_data !== 8'h47 || seed_ack !== 1'b0 || dir_ack !== 1'b0) begin
      bad++;
      $display("FAIL seed_x_write: wr=%b data=%h sack=%b dack=%b required 1 47 0 0", wr_uart, w_data, seed_ack, dir_ack);
    end
    tick();
    total++;
    if (wr_uart !== 1'b0) begin
      bad++;
      $display("FAIL seed_gap: wr=%b required 0", wr_uart);
    end
    tick();
    total++;
    if (wr_uart !== 1'b1 || w_data !== 8'h93 || seed_ack !== 1'b1) begin
      bad++;
      $display("FAIL seed_y_write: wr=%b data=%h sack=%b required 1 93 1", wr_uart, w_data, seed_ack);
    end
    tick();
    seed_req = 1'b0;
    tick();
    total++;
    if (wr_uart !== 1'b0 || seed_ack !== 1'b0) begin
      bad++;
      $display("FAIL seed_after_gap: wr=%b sack=%b required 0 0", wr_uart, seed_ack);
    end
    tick();
    total++;
    if (wr_uart !== 1'b1 || w_data !== 8'h05 || dir_ack !== 1'b1) begin
      bad++;
      $display("FAIL seed_then_dir: wr=%b data=%h dack=%b required 1 05 1", wr_uart, w_data, dir_ack);
    end
    tick();
    dir_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_full_between();
    int writes;
    seed_x = 5'd7; seed_y = 5'd19; seed_req = 1'b1;
    tick();
    total++;
    if (wr_uart !== 1'b1 || w_data !== 8'h47) begin
      bad++;
      $display("FAIL full_x_write: wr=%b data=%h required 1 47", wr_uart, w_data);
    end
    tx_full = 1'b1;
    evt_code = 5'd4; evt_req = 1'b1;
    dir = 3'b001; dir_req = 1'b1;
    writes = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wr_uart) writes++;
    end
    total++;
    if (writes != 0) begin
      bad++;
      $display("FAIL full_hold: writes=%0d required 0", writes);
    end
    tx_full = 1'b0;
    tick();
    total++;
    if (wr_uart !== 1'b1 || w_data !== 8'h93 || seed_ack !== 1'b1 || evt_ack !== 1'b0) begin
      bad++;
      $display("FAIL full_y_write: wr=%b data=%h sack=%b eack=%b required 1 93 1 0", wr_uart, w_data, seed_ack, evt_ack);
    end
    tick();
    seed_req = 1'b0;
    tick(); tick();
    total++;
    if (wr_uart !== 1'b1 || w_data !== 8'hC4 || evt_ack !== 1'b1) begin
      bad++;
      $display("FAIL full_evt_next: wr=%b data=%h eack=%b required 1 c4 1", wr_uart, w_data, evt_ack);
    end
    tick();
    evt_req = 1'b0;
    tick(); tick();
    total++;
    if (wr_uart !== 1'b1 || w_data !== 8'h01 || dir_ack !== 1'b1) begin
      bad++;
      $display("FAIL full_dir_last: wr=%b data=%h dack=%b required 1 01 1", wr_uart, w_data, dir_ack);
    end
    tick();
    dir_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_singleplayer();
    int writes;
    int sacks;
    singleplayer = 1'b1;
    evt_code = 5'd4; evt_req = 1'b1;
    tick();
    total++;
    if (evt_ack !== 1'b1 || wr_uart !== 1'b0) begin
      bad++;
      $display("FAIL sp_evt_ack: eack=%b wr=%b required 1 0", evt_ack, wr_uart);
    end
    tick();
    evt_req = 1'b0;
    total++;
    if (evt_ack !== 1'b0 || wr_uart !== 1'b0) begin
      bad++;
      $display("FAIL sp_evt_once: eack=%b wr=%b required 0 0", evt_ack, wr_uart);
    end
    tick();
    singleplayer = 1'b0;
    seed_x = 5'd3; seed_y = 5'd9; seed_req = 1'b1;
    tick();
    total++;
    if (wr_uart !== 1'b1 || w_data !== 8'h43) begin
      bad++;
      $display("FAIL sp_seed_x: wr=%b data=%h required 1 43", wr_uart, w_data);
    end
    singleplayer = 1'b1;
    tick();
    total++;
    if (seed_ack !== 1'b1 || wr_uart !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL sp_seed_abort: sack=%b wr=%b busy=%b required 1 0 0", seed_ack, wr_uart, busy);
    end
    tick();
    seed_req = 1'b0;
    singleplayer = 1'b0;
    writes = 0; sacks = 0;
    for (int i = 0; i < 6; i++) begin
      if (wr_uart) writes++;
      if (seed_ack) sacks++;
      tick();
    end
    total++;
    if (writes != 0 || sacks != 0) begin
      bad++;
      $display("FAIL sp_no_y: writes=%0d sacks=%0d required 0 0", writes, sacks);
    end
  endtask

  task automatic test_rst_in_gap();
    int writes;
    int sacks;
    seed_x = 5'd7; seed_y = 5'd19; seed_req = 1'b1;
    tick();
    tick();
    rst = 1'b1; seed_req = 1'b0;
    tick();
    rst = 1'b0;
    total++;
    if ({wr_uart, w_data, busy, seed_ack, dir_ack, evt_ack} !== 13'd0) begin
      bad++;
      $display("FAIL rst_gap_outputs: wr=%b data=%h busy=%b sack=%b required all 0", wr_uart, w_data, busy, seed_ack);
    end
    writes = 0; sacks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wr_uart) writes++;
      if (seed_ack) sacks++;
    end
    total++;
    if (writes != 0 || sacks != 0) begin
      bad++;
      $display("FAIL rst_gap_no_y: writes=%0d sacks=%0d required 0 0", writes, sacks);
    end
  endtask

`ifdef LINK_HEARTBEAT_EN
  task automatic test_heartbeat();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!wr_uart && n < 40);
    total++;
    if (wr_uart !== 1'b1 || w_data !== 8'hDF) begin
      bad++;
      $display("FAIL hb_first: wr=%b data=%h after %0d cycles required 1 df", wr_uart, w_data, n);
    end
    n = 0;
    do begin tick(); n++; end while (!wr_uart && n < 40);
    total++;
    if (n != 18 || w_data !== 8'hDF) begin
      bad++;
      $display("FAIL hb_period: spacing=%0d data=%h required 18 df", n, w_data);
    end
    repeat (5) tick();
    dir = 3'b011; dir_req = 1'b1;
    tick();
    total++;
    if (wr_uart !== 1'b1 || w_data !== 8'h03) begin
      bad++;
      $display("FAIL hb_dir_write: wr=%b data=%h required 1 03", wr_uart, w_data);
    end
    n = 0;
    do begin
      tick(); n++;
      if (n == 1) dir_req = 1'b0;
    end while (!wr_uart && n < 40);
    total++;
    if (n != 18 || w_data !== 8'hDF) begin
      bad++;
      $display("FAIL hb_restart: spacing=%0d data=%h required 18 df", n, w_data);
    end
  endtask
`else
  task automatic test_no_heartbeat();
    int writes;
    writes = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wr_uart) writes++;
    end
    total++;
    if (writes != 0) begin
      bad++;
      $display("FAIL no_heartbeat: writes=%0d required 0", writes);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; singleplayer = 1'b0; tx_full = 1'b0;
    seed_req = 1'b0; dir_req = 1'b0; evt_req = 1'b0;
    seed_x = '0; seed_y = '0; evt_code = '0; dir = '0;
    repeat (3) tick();
    test_reset();
    test_dir();
    test_seed_dir();
    test_full_between();
    test_singleplayer();
    test_rst_in_gap();
`ifdef LINK_HEARTBEAT_EN
    test_heartbeat();
`else
    test_no_heartbeat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
